// File: rtl/tcam_rule_ctrl.sv
// tcam_rule_ctrl: register front-end that stages one TCAM rule and, on
// command, quiesces the lookup dispatcher and programs or clears entries.
module tcam_rule_ctrl #(
  parameter int AXIL_APP_CTRL_DATA_WIDTH = 32,
  parameter int AXIL_APP_CTRL_ADDR_WIDTH = 16,
  parameter int AXIL_APP_CTRL_STRB_WIDTH = AXIL_APP_CTRL_DATA_WIDTH / 8,
  parameter int TCAM_ADDR_WIDTH          = 4,
  parameter int TCAM_KEY_WIDTH           = 128,
  parameter int TCAM_DATA_WIDTH          = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [AXIL_APP_CTRL_ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [AXIL_APP_CTRL_DATA_WIDTH-1:0] reg_wr_data,
  input  logic [AXIL_APP_CTRL_STRB_WIDTH-1:0] reg_wr_strb,
  input  logic                                reg_wr_en,
  output logic                                reg_wr_wait,
  output logic                                reg_wr_ack,
  input  logic [AXIL_APP_CTRL_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                                reg_rd_en,
  output logic [AXIL_APP_CTRL_DATA_WIDTH-1:0] reg_rd_data,
  output logic                                reg_rd_wait,
  output logic                                reg_rd_ack,
  output logic [TCAM_ADDR_WIDTH-1:0]          set_addr,
  output logic [TCAM_DATA_WIDTH-1:0]          set_data,
  output logic [TCAM_KEY_WIDTH-1:0]           set_key,
  output logic [TCAM_KEY_WIDTH-1:0]           set_xmask,
  output logic                                set_clr,
  output logic                                set_valid,
  input  logic                                lookup_idle,
  output logic                                lookup_hold
);

  localparam int DW        = AXIL_APP_CTRL_DATA_WIDTH;
  localparam int AW        = AXIL_APP_CTRL_ADDR_WIDTH;
  localparam int SW        = AXIL_APP_CTRL_STRB_WIDTH;
  localparam int TAW       = TCAM_ADDR_WIDTH;
  localparam int TDW       = TCAM_DATA_WIDTH;
  localparam int KW        = TCAM_KEY_WIDTH;
  localparam int KEY_WORDS = KW / 32;

  localparam logic [AW-1:0] A_CTRL   = AW'(32'h00);
  localparam logic [AW-1:0] A_STATUS = AW'(32'h04);
  localparam logic [AW-1:0] A_ADDR   = AW'(32'h08);
  localparam logic [AW-1:0] A_DATA   = AW'(32'h0C);
  localparam logic [AW-1:0] A_COUNT  = AW'(32'h30);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_PROGRAM,
    S_CLEAR_ALL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // staging registers written by software
  logic [TAW-1:0] r_stg_addr;
  logic [TDW-1:0] r_stg_data;
  logic [31:0]    r_key  [KEY_WORDS];
  logic [31:0]    r_mask [KEY_WORDS];
  logic [KW-1:0]  w_stg_key;
  logic [KW-1:0]  w_stg_mask;

  // payload frozen at command acceptance
  logic [TAW-1:0] r_snap_addr;
  logic [TDW-1:0] r_snap_data;
  logic [KW-1:0]  r_snap_key;
  logic [KW-1:0]  r_snap_mask;
  logic           r_cmd_all;
  logic           r_cmd_one;

  logic        r_done;
  logic        r_err;
  logic [31:0] r_count;

  logic          r_wr_ack;
  logic          r_rd_ack;
  logic [DW-1:0] r_rd_data;

  logic [TAW-1:0] r_set_addr;
  logic [TDW-1:0] r_set_data;
  logic [KW-1:0]  r_set_key;
  logic [KW-1:0]  r_set_mask;
  logic           r_set_clr;
  logic           r_set_valid;

  logic [TAW-1:0] w_set_addr_next;
  logic [TDW-1:0] w_set_data_next;
  logic [KW-1:0]  w_set_key_next;
  logic [KW-1:0]  w_set_mask_next;
  logic           w_set_clr_next;
  logic           w_set_valid_next;

  logic                 w_busy;
  logic                 w_wr_ctrl;
  logic                 w_wr_status;
  logic                 w_wr_addr;
  logic                 w_wr_data;
  logic [KEY_WORDS-1:0] w_wr_key_hit;
  logic [KEY_WORDS-1:0] w_wr_mask_hit;
  logic                 w_wr_guarded;
  logic                 w_wr_err;
  logic [2:0]           w_cmd_bits;
  logic                 w_accept;
  logic                 w_w1c;
  logic [DW-1:0]        w_rd_mux;

  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // per-word key/mask decode and flattening of the staged words
  genvar gi;
  generate
    for (gi = 0; gi < KEY_WORDS; gi++) begin : g_words
      assign w_wr_key_hit[gi]    = (reg_wr_addr == AW'(32'h10 + 4 * gi));
      assign w_wr_mask_hit[gi]   = (reg_wr_addr == AW'(32'h20 + 4 * gi));
      assign w_stg_key[32*gi +: 32]  = r_key[gi];
      assign w_stg_mask[32*gi +: 32] = r_mask[gi];
    end
  endgenerate

  assign w_busy       = (r_state != S_IDLE);
  assign w_wr_ctrl    = (reg_wr_addr == A_CTRL);
  assign w_wr_status  = (reg_wr_addr == A_STATUS);
  assign w_wr_addr    = (reg_wr_addr == A_ADDR);
  assign w_wr_data    = (reg_wr_addr == A_DATA);
  assign w_wr_guarded = w_wr_ctrl | w_wr_addr | w_wr_data | (|w_wr_key_hit) | (|w_wr_mask_hit);
  assign w_wr_err     = reg_wr_en & w_busy & w_wr_guarded;
  assign w_cmd_bits   = reg_wr_data[2:0] & {3{reg_wr_strb[0]}};
  assign w_accept     = reg_wr_en & w_wr_ctrl & ~w_busy & (|w_cmd_bits);
  assign w_w1c        = reg_wr_en & w_wr_status & reg_wr_strb[0];

  assign reg_wr_wait = 1'b0;
  assign reg_rd_wait = 1'b0;
  assign reg_wr_ack  = r_wr_ack;
  assign reg_rd_ack  = r_rd_ack;
  assign reg_rd_data = r_rd_data;
  assign set_addr    = r_set_addr;
  assign set_data    = r_set_data;
  assign set_key     = r_set_key;
  assign set_xmask   = r_set_mask;
  assign set_clr     = r_set_clr;
  assign set_valid   = r_set_valid;
  assign lookup_hold = w_busy;

  // staging register writes; ignored while a command is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_addr <= '0;
      r_stg_data <= '0;
      for (int i = 0; i < KEY_WORDS; i++) begin
        r_key[i]  <= '0;
        r_mask[i] <= '0;
      end
    end else if (reg_wr_en && !w_busy) begin
      if (w_wr_addr) r_stg_addr <= TAW'(f_merge(DW'(r_stg_addr), reg_wr_data, reg_wr_strb));
      if (w_wr_data) r_stg_data <= TDW'(f_merge(DW'(r_stg_data), reg_wr_data, reg_wr_strb));
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (w_wr_key_hit[i])  r_key[i]  <= f_merge(r_key[i], reg_wr_data, reg_wr_strb);
        if (w_wr_mask_hit[i]) r_mask[i] <= f_merge(r_mask[i], reg_wr_data, reg_wr_strb);
      end
    end
  end

  // latch command and snapshot the payload when a command is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_addr <= '0;
      r_snap_data <= '0;
      r_snap_key  <= '0;
      r_snap_mask <= '0;
      r_cmd_all   <= 1'b0;
      r_cmd_one   <= 1'b0;
    end else if (w_accept) begin
      r_snap_addr <= r_stg_addr;
      r_snap_data <= r_stg_data;
      r_snap_key  <= w_stg_key;
      r_snap_mask <= w_stg_mask;
      r_cmd_all   <= w_cmd_bits[2];
      r_cmd_one   <= w_cmd_bits[1] & ~w_cmd_bits[2];
    end
  end

  // status bits and completion counter; a DONE set beats a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      if (r_state == S_DONE) r_done <= 1'b1;
      else if (w_w1c && reg_wr_data[1]) r_done <= 1'b0;
      if (w_wr_err) r_err <= 1'b1;
      else if (w_w1c && reg_wr_data[2]) r_err <= 1'b0;
      if (r_state == S_DONE) r_count <= r_count + 32'd1;
    end
  end

  // read data mux
  always_comb begin
    w_rd_mux = '0;
    if (reg_rd_addr == A_STATUS) w_rd_mux = DW'({r_err, r_done, w_busy});
    if (reg_rd_addr == A_ADDR)   w_rd_mux = DW'(r_stg_addr);
    if (reg_rd_addr == A_DATA)   w_rd_mux = DW'(r_stg_data);
    if (reg_rd_addr == A_COUNT)  w_rd_mux = r_count;
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (reg_rd_addr == AW'(32'h10 + 4 * i)) w_rd_mux = r_key[i];
      if (reg_rd_addr == AW'(32'h20 + 4 * i)) w_rd_mux = r_mask[i];
    end
  end

  // register handshake: single-cycle acks one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_wr_ack  <= reg_wr_en;
      r_rd_ack  <= reg_rd_en;
      r_rd_data <= reg_rd_en ? w_rd_mux : '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state and next values of the registered programming outputs
  always_comb begin
    w_state_next     = r_state;
    w_set_valid_next = 1'b0;
    w_set_clr_next   = 1'b0;
    w_set_addr_next  = '0;
    w_set_data_next  = '0;
    w_set_key_next   = '0;
    w_set_mask_next  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_QUIESCE;
      end
      S_QUIESCE: begin
        if (lookup_idle) begin
          w_set_valid_next = 1'b1;
          if (r_cmd_all) begin
            w_state_next   = S_CLEAR_ALL;
            w_set_clr_next = 1'b1;
          end else begin
            w_state_next    = S_PROGRAM;
            w_set_clr_next  = r_cmd_one;
            w_set_addr_next = r_snap_addr;
            w_set_data_next = r_snap_data;
            w_set_key_next  = r_snap_key;
            w_set_mask_next = r_snap_mask;
          end
        end
      end
      S_PROGRAM: begin
        w_state_next = S_DONE;
      end
      S_CLEAR_ALL: begin
        // r_set_addr doubles as the sweep index
        if (r_set_addr == {TAW{1'b1}}) begin
          w_state_next = S_DONE;
        end else begin
          w_set_valid_next = 1'b1;
          w_set_clr_next   = 1'b1;
          w_set_addr_next  = r_set_addr + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // registered TCAM programming outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_valid <= 1'b0;
      r_set_clr   <= 1'b0;
      r_set_addr  <= '0;
      r_set_data  <= '0;
      r_set_key   <= '0;
      r_set_mask  <= '0;
    end else begin
      r_set_valid <= w_set_valid_next;
      r_set_clr   <= w_set_clr_next;
      r_set_addr  <= w_set_addr_next;
      r_set_data  <= w_set_data_next;
      r_set_key   <= w_set_key_next;
      r_set_mask  <= w_set_mask_next;
    end
  end

endmodule

// File: tb/tb_tcam_rule_ctrl.sv
// tb_tcam_rule_ctrl: directed plus randomized checks of tcam_rule_ctrl
// against a register-level model of the rule staging and command flow.
module tb_tcam_rule_ctrl;
  localparam int AW   = 16;
  localparam int TAW  = 4;
  localparam int TDW  = 4;
  localparam int KW   = 128;
  localparam int NENT = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  reg_wr_addr = '0;
  logic [31:0]    reg_wr_data = '0;
  logic [3:0]     reg_wr_strb = '0;
  logic           reg_wr_en = 1'b0;
  logic           reg_wr_wait, reg_wr_ack;
  logic [AW-1:0]  reg_rd_addr = '0;
  logic           reg_rd_en = 1'b0;
  logic [31:0]    reg_rd_data;
  logic           reg_rd_wait, reg_rd_ack;
  logic [TAW-1:0] set_addr;
  logic [TDW-1:0] set_data;
  logic [KW-1:0]  set_key, set_xmask;
  logic           set_clr, set_valid;
  logic           lookup_idle = 1'b1;
  logic           lookup_hold;

  always #5 clk = ~clk;

  tcam_rule_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
    .set_addr(set_addr), .set_data(set_data), .set_key(set_key), .set_xmask(set_xmask),
    .set_clr(set_clr), .set_valid(set_valid),
    .lookup_idle(lookup_idle), .lookup_hold(lookup_hold)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TAW-1:0] addr;
    logic [TDW-1:0] data;
    logic [KW-1:0]  key;
    logic [KW-1:0]  mask;
    logic           clr;
    int             cyc;
  } ev_t;
  ev_t evq[$];

  // record every programming strobe seen by the TCAM
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && set_valid) begin
      e.addr = set_addr; e.data = set_data; e.key = set_key;
      e.mask = set_xmask; e.clr = set_clr; e.cyc = cyc;
      evq.push_back(e);
    end
  end

  // reference model of the register file
  logic [31:0] m_addr, m_data, m_count;
  logic [31:0] m_key [4];
  logic [31:0] m_mask [4];
  logic        m_done, m_err, m_busy;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic void m_reset();
    m_addr = 0; m_data = 0; m_count = 0; m_done = 0; m_err = 0; m_busy = 0;
    for (int i = 0; i < 4; i++) begin m_key[i] = 0; m_mask[i] = 0; end
  endfunction

  function automatic void m_write(input int a, input logic [31:0] d, input logic [3:0] s);
    bit staging;
    staging = (a == 8) || (a == 12) || (a >= 16 && a < 48 && a % 4 == 0);
    if (a == 4 && s[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end
    if (m_busy && (staging || a == 0)) m_err = 1;
    else if (!m_busy && staging) begin
      if (a == 8)       m_addr = merge(m_addr, d, s);
      else if (a == 12) m_data = merge(m_data, d, s);
      else if (a < 32)  m_key[(a - 16) / 4] = merge(m_key[(a - 16) / 4], d, s);
      else              m_mask[(a - 32) / 4] = merge(m_mask[(a - 32) / 4], d, s);
    end
  endfunction

  function automatic logic [31:0] m_status();
    return {29'd0, m_err, m_done, m_busy};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    reg_wr_addr = AW'(a); reg_wr_data = d; reg_wr_strb = s; reg_wr_en = 1'b1;
    @(negedge clk);
    reg_wr_en = 1'b0;
    chk("wr_ack", reg_wr_ack, 1);
    m_write(a, d, s);
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    @(negedge clk);
    reg_rd_addr = AW'(a); reg_rd_en = 1'b1;
    @(negedge clk);
    reg_rd_en = 1'b0;
    chk("rd_ack", reg_rd_ack, 1);
    chk(tag, reg_rd_data, exp);
    $display("read  addr=%02h data=%08h expected=%08h", a, reg_rd_data, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (lookup_hold && n < 100) begin @(negedge clk); n++; end
    chk("idle_timeout", lookup_hold, 0);
    m_busy = 0; m_done = 1; m_count = m_count + 1;
  endtask

  // issue a command, keep the dispatcher busy for 'hold' cycles, then release it
  task automatic run_cmd(input logic [31:0] cmd, input int hold);
    lookup_idle = 1'b0;
    wr(0, cmd, 4'hF);
    m_busy = 1;
    chk("hold_quiesce", lookup_hold, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_wait", lookup_hold, 1);
      chk("no_set_early", evq.size(), 0);
    end
    lookup_idle = 1'b1;
    @(negedge clk);
    chk("set_after_idle", set_valid, 1);
    wait_idle();
  endtask

  task automatic check_single(input logic clr);
    ev_t e;
    chk("ev_count", evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      $display("set   addr=%0d data=%0h clr=%0b key=%h mask=%h", e.addr, e.data, e.clr, e.key, e.mask);
      chk("ev_addr", e.addr, m_addr[TAW-1:0]);
      chk("ev_data", e.data, m_data[TDW-1:0]);
      chk("ev_key",  e.key,  {m_key[3], m_key[2], m_key[1], m_key[0]});
      chk("ev_mask", e.mask, {m_mask[3], m_mask[2], m_mask[1], m_mask[0]});
      chk("ev_clr",  e.clr,  clr);
    end
    evq.delete();
  endtask

  initial begin
    logic [31:0] cmd, v;
    logic [31:0] old_key0;
    int w, n;

    m_reset();
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_set_valid", set_valid, 0);
    chk("rst_hold", lookup_hold, 0);
    chk("rst_acks", {reg_wr_ack, reg_rd_ack, reg_wr_wait, reg_rd_wait}, 0);
    chk("rst_set_bus", {set_addr, set_data, set_key, set_xmask, set_clr}, 0);
    rst_n = 1'b1;
    rd_chk("status_rst", 4, 0);
    rd_chk("count_rst", 'h30, 0);

    // single commit with the documented payload
    wr(8, 3, 4'hF); wr(12, 5, 4'hF); wr('h10, 32'h0A000001, 4'hF);
    run_cmd(1, 0);
    check_single(1'b0);
    rd_chk("status_done", 4, 32'h2);
    rd_chk("count_one", 'h30, 1);
    rd_chk("unmapped_rd", 'h40, 0);
    wr('h44, 32'hFFFF_FFFF, 4'hF);
    rd_chk("ctrl_rd_zero", 0, 0);

    // randomized rule staging with byte strobes
    for (int it = 0; it < 6; it++) begin
      wr(8, $urandom, 4'(($urandom_range(1, 15))));
      wr(12, $urandom, 4'(($urandom_range(1, 15))));
      for (int i = 0; i < 4; i++) begin
        wr('h10 + 4 * i, $urandom, 4'(($urandom_range(1, 15))));
        wr('h20 + 4 * i, $urandom, 4'(($urandom_range(1, 15))));
      end
      w = $urandom_range(0, 3);
      rd_chk("key_readback", 'h10 + 4 * w, m_key[w]);
      rd_chk("mask_readback", 'h20 + 4 * w, m_mask[w]);
      cmd = 32'($urandom_range(1, 3));
      run_cmd(cmd, $urandom_range(0, 4));
      check_single(cmd[1]);
      rd_chk("status_rand", 4, m_status());
      rd_chk("count_rand", 'h30, m_count);
    end

    // dispatcher stays busy for 10 cycles
    run_cmd(1, 10);
    check_single(1'b0);

    // staging writes during a command are refused and flagged
    wr(4, 6, 4'hF);
    lookup_idle = 1'b0;
    wr(0, 1, 4'hF);
    m_busy = 1;
    old_key0 = m_key[0];
    v = ~old_key0;
    wr('h10, v, 4'hF);
    wr(8, 32'h9, 4'hF);
    rd_chk("status_busy_err", 4, 32'h5);
    lookup_idle = 1'b1;
    wait_idle();
    check_single(1'b0);
    rd_chk("key_unchanged", 'h10, old_key0);
    wr(4, 4, 4'hF);
    rd_chk("err_cleared", 4, 32'h2);

    // W1C of DONE on the same edge that sets DONE: the set wins
    wr(0, 1, 4'hF);
    m_busy = 1;
    reg_wr_addr = AW'(4); reg_wr_data = 2; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
    repeat (3) @(negedge clk);
    reg_wr_en = 1'b0;
    wait_idle();
    check_single(1'b0);
    rd_chk("done_set_wins", 4, 32'h2);

    // all command bits set: only the full clear sweep runs
    run_cmd(7, 2);
    chk("ca_count", evq.size(), NENT);
    for (int i = 0; i < evq.size(); i++) begin
      chk("ca_addr", evq[i].addr, i);
      chk("ca_clr", evq[i].clr, 1);
      if (i > 0) chk("ca_consec", evq[i].cyc - evq[i-1].cyc, 1);
    end
    $display("sweep entries=%0d", evq.size());
    evq.delete();
    rd_chk("count_after_ca", 'h30, m_count);

    // reset in the middle of a clear sweep
    wr(0, 4, 4'hF);
    m_busy = 1;
    n = 0;
    while (!(set_valid && set_addr == 7) && n < 50) begin @(negedge clk); n++; end
    chk("sweep_reach_7", set_addr, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", set_valid, 0);
    chk("rst_mid_bus", {set_clr, set_addr}, 0);
    chk("rst_mid_hold", lookup_hold, 0);
    m_reset();
    evq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_resume", evq.size(), 0);
    chk("idle_after_rst", lookup_hold, 0);
    rd_chk("status_after_rst", 4, 0);
    rd_chk("count_after_rst", 'h30, 0);
    rd_chk("key_after_rst", 'h10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcam_rule_ctrl.md
TCAM_RULE_CTRL -- requirements
Module: tcam_rule_ctrl

Interface
REQ-001 SHALL have parameter AXIL_APP_CTRL_DATA_WIDTH, default 32, register data width; only 32 is supported.
REQ-002 SHALL have parameter AXIL_APP_CTRL_ADDR_WIDTH, default 16, register byte-address width.
REQ-003 SHALL have parameter AXIL_APP_CTRL_STRB_WIDTH, default AXIL_APP_CTRL_DATA_WIDTH/8, write-strobe width.
REQ-004 SHALL have parameter TCAM_ADDR_WIDTH, default 4, TCAM entry-index width.
REQ-005 SHALL have parameter TCAM_KEY_WIDTH, default 128, key/mask width; must be a multiple of 32 and at most 128.
REQ-006 SHALL have parameter TCAM_DATA_WIDTH, default 4, action-data width; at most 32.
REQ-007 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- reg_wr_addr / reg_wr_data / reg_wr_strb / reg_wr_en  in  ADDR / 32 / STRB / 1  register write request.
- reg_wr_wait / reg_wr_ack  out  1 / 1  write handshake.
- reg_rd_addr / reg_rd_en  in  ADDR / 1  register read request.
- reg_rd_data / reg_rd_wait / reg_rd_ack  out  32 / 1 / 1  read response.
- set_addr / set_data / set_key / set_xmask  out  TCAM_ADDR / TCAM_DATA / KEY / KEY  TCAM programming payload.
- set_clr / set_valid  out  1 / 1  clear-entry flag and one-cycle program strobe.
- lookup_idle  in  1  dispatcher FSM is in IDLE with no TCAM request outstanding.
- lookup_hold  out  1  dispatcher must not leave IDLE while high.

Function
REQ-008 Register map (byte addresses): 0x00 CTRL (W: bit0 COMMIT, bit1 CLEAR_ONE, bit2 CLEAR_ALL; R: 0); 0x04 STATUS (R: bit0 BUSY, bit1 DONE, bit2 ERR; W1C on bits 1-2); 0x08 ADDR; 0x0C DATA; 0x10+4i KEY word i; 0x20+4i MASK word i; 0x30 COMMIT_COUNT (R only). Word 0 holds bits [31:0].
REQ-009 Staging registers SHALL honour reg_wr_strb per byte; unmapped reads return 0; unmapped writes are acked and ignored.
REQ-010 reg_wr_wait and reg_rd_wait SHALL be tied 0; the ack pulses for 1 cycle, one cycle after the corresponding _en; reg_rd_data is valid with reg_rd_ack.
REQ-011 FSM states: IDLE, QUIESCE, PROGRAM, CLEAR_ALL, DONE.
REQ-012 IDLE: a CTRL write with a command bit set latches the command, sets BUSY and goes to QUIESCE next cycle. Priority: CLEAR_ALL > CLEAR_ONE > COMMIT.
REQ-013 lookup_hold SHALL be 1 in QUIESCE, PROGRAM, CLEAR_ALL and DONE, and 0 in IDLE.
REQ-014 QUIESCE: wait for lookup_idle=1. The first cycle it is sampled high, go to PROGRAM (COMMIT/CLEAR_ONE) or CLEAR_ALL.
REQ-015 PROGRAM: drive set_valid=1 for exactly 1 cycle with staged ADDR/DATA/KEY/MASK; set_clr=1 only for CLEAR_ONE; then go to DONE.
REQ-016 CLEAR_ALL: assert set_valid=1 and set_clr=1 for 2^TCAM_ADDR_WIDTH consecutive cycles, with set_addr = 0 .. 2^TCAM_ADDR_WIDTH-1; after the last index go to DONE.
REQ-017 DONE (1 cycle): set DONE, clear BUSY, increment COMMIT_COUNT by 1 (32-bit wrap; CLEAR_ALL counts once), then return to IDLE.
REQ-018 A CTRL or staging-register write while BUSY SHALL be acked, SHALL NOT modify state or staging, and SHALL set ERR.
REQ-019 The staged payload SHALL be snapshot on command acceptance; set_* outputs are registered.
REQ-020 A STATUS W1C write in the same cycle as the DONE set SHALL leave DONE=1 (set wins).

Reset
REQ-021 While rst_n=0, all of the following SHALL be 0 and the FSM SHALL be IDLE: outputs, staging registers, STATUS and COMMIT_COUNT. Reset mid-CLEAR_ALL aborts the sweep; the sweep does not resume.

Verification
- ADDR=3, DATA=0x5, KEY=0x0A000001 (other words 0), MASK=0, COMMIT, lookup_idle=1 -> one set_valid with set_addr=3, set_data=5, set_clr=0; STATUS reads 0x2; COMMIT_COUNT=1.
- CLEAR_ALL with TCAM_ADDR_WIDTH=4 -> 16 consecutive set_valid/set_clr cycles, addresses 0..15; COMMIT_COUNT increments by 1.
- lookup_idle held 0 for 10 cycles after COMMIT -> no set_valid and lookup_hold=1 throughout; set_valid occurs in the cycle after lookup_idle rises.
- KEY write during BUSY -> acked, staged KEY unchanged, STATUS.ERR=1; W1C 0x4 -> ERR=0.
- CTRL=0x7 -> CLEAR_ALL sweep only; no single PROGRAM cycle.
- rst_n low at sweep index 7 -> outputs 0 immediately; after release FSM is IDLE and lookup_hold=0.
